pipelined_dp_block_ram: RTL
===========================

# pipelined_dp_block_ram

Dual-port, byte-writable block memory with a configurable read-pipeline depth, selectable read-during-write behaviour, deterministic write-collision resolution and a hardware clear engine. It is the general-purpose successor to the single- and dual-port raw RAMs. It sits behind the instruction and data memory ports of the simulated SoC, and is also used for peripheral buffers that need zeroing at run time.

## Interface
Parameters:
- `abits`, 8: address bits; depth is 2^abits words.
- `dbytes`, 4: data bytes per word.
- `blen`, 8: bits per byte.
- `rd_latency`, 1: read latency in cycles; legal range 1..4; other values are a elaboration `$error`.
- `rdw_mode`, `RDW_READ_FIRST`: same-port read-during-write returns old data (`RDW_READ_FIRST`) or newly written bytes merged with old (`RDW_WRITE_FIRST`).
- `dbits`, localparam, dbytes*blen.

Ports (x is one of a, b; both ports are identical):
- `clk`  in  1  RAM clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `x_re`  in  1  read enable.
- `x_we`  in  dbytes  per-byte write enable.
- `x_addr`  in  abits  word address.
- `x_wdata`  in  dbits  write data.
- `x_rdata`  out  dbits  read data; held between valid pulses.
- `x_rvalid`  out  1  one-cycle pulse marking `x_rdata` valid.
- `clear`  in  1  request a full memory clear.
- `busy`  out  1  clear engine active; all port accesses are ignored.
- `collision`  out  1  registered pulse: both ports wrote at least one common byte of the same address in the previous cycle.

## Operation
- Storage: 2^abits x dbits array. It has no reset; contents survive `rst_n` unless the clear engine runs.
- Write: byte i of `x_addr` is updated at the clock edge when `x_we[i]` is set and `busy` is low.
- Collision rule: if both ports write the same address and byte, port A's byte wins and `collision` pulses on the next cycle. Bytes written by only one port are written normally.
- Read: `x_re` captures `storage[x_addr]` at the edge. Data and `x_rvalid` then pass through a `rd_latency-1` stage delay line.
- Reading with `x_we` zero is pure read. `x_we` without `x_re` produces no `x_rvalid`.
- Read-during-write on the same port follows `rdw_mode`.
- Cross-port reads of an address written in the same cycle always return old data.
- Clear FSM has three states:
  - `CLR_IDLE`: on `clear` go to `CLR_RUN` with counter set to 0.
  - `CLR_RUN`: write zero to `storage[counter]` and increment. At counter 2^abits-1, go to `CLR_DONE`.
  - `CLR_DONE`: one cycle, then return to `CLR_IDLE`.
- `busy` is high in `CLR_RUN` and `CLR_DONE`.
- While `busy` is high: port writes are dropped, `x_re` is ignored (no `x_rvalid`), and `clear` is ignored.
- Reads already in the delay line when the clear starts still complete, carrying pre-clear data.

## Timing
- Reset values: `x_rdata` = 0, `x_rvalid` = 0, `collision` = 0, all pipeline stages invalid.
- Reset values with the clear engine compiled in: FSM = `CLR_RUN`, counter = 0, `busy` = 1. Memory is therefore auto-cleared after every reset.
- Reset values without the clear engine: `busy` = 0.
- Read latency: `x_re` sampled at edge N gives `x_rvalid` high in the cycle following edge N+rd_latency-1. For rd_latency = 1, that is the cycle right after the request.
- Back-to-back reads are fully pipelined at one per cycle per port.
- Clear duration: `busy` rises the cycle after `clear` is sampled and stays high for 2^abits+1 cycles. The first accepted access is in the cycle `busy` reads 0.
- Reset mid-clear: the FSM restarts at counter 0 (with the macro) or drops to `CLR_IDLE` (without it). Pipeline contents are discarded.
- `clear` sampled in the same cycle as a port write: the write is performed, then the clear starts.

## Configuration
- `BOA_RAM_CLEAR_EN` defined: the clear FSM, counter and auto-clear on reset are present.
- `BOA_RAM_CLEAR_EN` undefined: the FSM and counter are not generated. `busy` is tied to 0, `clear` is ignored, and the memory is ready in the first cycle after reset with its contents unchanged.

## Structure
- Package `boa_ram_pkg`:
  - `rdw_mode_t` enum (`RDW_READ_FIRST`, `RDW_WRITE_FIRST`).
  - `clr_state_t` enum.
  - `RD_LATENCY_MAX` = 4.
- Sub-module `ram_rd_pipe`: parametrised `{valid, data}` delay line of depth `rd_latency-1`, with synchronous active-low reset. It is instantiated once per port; depth 0 is a passthrough.

## Test plan
- Write/read latency: rd_latency = 3, A writes 0xDEADBEEF to address 5 (we = 4'hF), then A reads address 5. Required: `a_rvalid` pulses 3 cycles after the read, with `a_rdata` = 0xDEADBEEF.
- Byte merge: address 7 holds 0x11223344; A writes we = 4'b0101 with wdata 0xAABBCCDD. A read of address 7 returns 0x11BB33DD.
- Collision: same cycle, A writes 0x000000AA and B writes 0x000000BB to address 3, both with we = 4'h1. Required: `collision` = 1 the next cycle only; a read of address 3 returns 0x000000AA.
- Read-during-write: A reads and writes 0x55 to address 9, which holds 0x12. READ_FIRST returns 0x12; WRITE_FIRST returns 0x55. In the same cycle, B reads address 9 and gets 0x12.
- Clear: abits = 4; fill all words with 0xFF; pulse `clear`. `busy` stays high for 17 cycles; writes and reads issued during `busy` produce no effect and no `rvalid`. Afterwards, all 16 words read back as 0.
- Reset: after reset (macro defined), `busy` = 1 for 2^abits+1 cycles and all outputs are 0. Asserting `rst_n` = 0 mid-clear restarts the counter at 0.

Source files
------------

// File: rtl/boa_ram_pkg.sv
// Shared types and limits for the pipelined dual-port block RAM.
package boa_ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_t;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

  localparam int unsigned RD_LATENCY_MAX = 4;

  // Stages after the capture register; tolerates an illegal latency of 0.
  function automatic int unsigned rd_pipe_depth(input int unsigned lat);
    return (lat > 0) ? lat - 1 : 0;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// {valid, data} delay line; data only advances with its valid bit so the
// output holds the last returned word between pulses.
module ram_rd_pipe #(
  parameter int unsigned depth = 0,
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  output logic [width-1:0] out_data
);

  if (depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;
    assign out_valid   = in_valid;
    assign out_data    = in_data;
  end else begin : g_stages
    logic [depth-1:0] valid_q;
    logic [width-1:0] data_q [depth];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < depth; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        if (in_valid) data_q[0] <= in_data;
        for (int unsigned i = 1; i < depth; i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[depth-1];
    assign out_data  = data_q[depth-1];
  end

endmodule

// File: rtl/pipelined_dp_block_ram.sv
// Dual-port byte-writable RAM with read pipeline, RDW mode and collision flag.
// Define BOA_RAM_CLEAR_EN to build the clear engine (auto-clear after reset).
module pipelined_dp_block_ram
  import boa_ram_pkg::*;
#(
  parameter int unsigned abits      = 8,
  parameter int unsigned dbytes     = 4,
  parameter int unsigned blen       = 8,
  parameter int unsigned rd_latency = 1,
  parameter rdw_mode_t   rdw_mode   = RDW_READ_FIRST,
  localparam int unsigned dbits     = dbytes * blen
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_re,
  input  logic [dbytes-1:0] a_we,
  input  logic [abits-1:0]  a_addr,
  input  logic [dbits-1:0]  a_wdata,
  output logic [dbits-1:0]  a_rdata,
  output logic              a_rvalid,
  input  logic              b_re,
  input  logic [dbytes-1:0] b_we,
  input  logic [abits-1:0]  b_addr,
  input  logic [dbits-1:0]  b_wdata,
  output logic [dbits-1:0]  b_rdata,
  output logic              b_rvalid,
  input  logic              clear,
  output logic              busy,
  output logic              collision
);

  localparam int unsigned depth      = 1 << abits;
  localparam int unsigned pipe_depth = rd_pipe_depth(rd_latency);

  if (rd_latency < 1 || rd_latency > RD_LATENCY_MAX) begin : g_bad_latency
    $error("rd_latency %0d outside 1..%0d", rd_latency, RD_LATENCY_MAX);
  end

  logic [dbits-1:0]  mem [depth];
  logic              clr_we;
  logic [abits-1:0]  clr_addr;
  logic [dbytes-1:0] a_wen, b_wen;
  logic              a_ren, b_ren;
  logic              a_s0_valid, b_s0_valid;
  logic [dbits-1:0]  a_s0_data, b_s0_data;

  assign a_wen = busy ? '0 : a_we;
  assign b_wen = busy ? '0 : b_we;
  assign a_ren = a_re & ~busy;
  assign b_ren = b_re & ~busy;

  function automatic logic [dbits-1:0] merge(input logic [dbits-1:0]  old,
                                             input logic [dbits-1:0]  wdata,
                                             input logic [dbytes-1:0] wen);
    logic [dbits-1:0] r;
    r = old;
    for (int unsigned i = 0; i < dbytes; i++)
      if (wen[i]) r[i*blen +: blen] = wdata[i*blen +: blen];
    return r;
  endfunction

  // Port A is applied last so it wins any byte both ports write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int unsigned i = 0; i < dbytes; i++)
        if (b_wen[i]) mem[b_addr][i*blen +: blen] <= b_wdata[i*blen +: blen];
      for (int unsigned i = 0; i < dbytes; i++)
        if (a_wen[i]) mem[a_addr][i*blen +: blen] <= a_wdata[i*blen +: blen];
    end
  end

  // Capture stage; cross-port reads always see pre-write contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_s0_valid <= 1'b0;
      b_s0_valid <= 1'b0;
      a_s0_data  <= '0;
      b_s0_data  <= '0;
      collision  <= 1'b0;
    end else begin
      a_s0_valid <= a_ren;
      b_s0_valid <= b_ren;
      if (a_ren)
        a_s0_data <= (rdw_mode == RDW_WRITE_FIRST) ? merge(mem[a_addr], a_wdata, a_wen)
                                                   : mem[a_addr];
      if (b_ren)
        b_s0_data <= (rdw_mode == RDW_WRITE_FIRST) ? merge(mem[b_addr], b_wdata, b_wen)
                                                   : mem[b_addr];
      collision <= (a_addr == b_addr) && (|(a_wen & b_wen));
    end
  end

  ram_rd_pipe #(.depth(pipe_depth), .width(dbits)) u_a_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_s0_valid),
    .in_data   (a_s0_data),
    .out_valid (a_rvalid),
    .out_data  (a_rdata)
  );

  ram_rd_pipe #(.depth(pipe_depth), .width(dbits)) u_b_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_s0_valid),
    .in_data   (b_s0_data),
    .out_valid (b_rvalid),
    .out_data  (b_rdata)
  );

`ifdef BOA_RAM_CLEAR_EN
  clr_state_t       state, state_nxt;
  logic [abits-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLR_RUN;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != CLR_IDLE);
    end
  end

  // Sweep every word once, then one settling cycle before releasing the ports.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (clear) begin
          state_nxt = CLR_RUN;
          cnt_nxt   = '0;
        end
      end
      CLR_RUN: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == {abits{1'b1}}) state_nxt = CLR_DONE;
      end
      CLR_DONE: state_nxt = CLR_IDLE;
      default:  state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_addr = cnt;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign busy         = 1'b0;
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
`endif

endmodule
